// File: rtl/dram_line_if.sv
// Request/response channel between the L1 line FIFO and DRAM (or its stand-in).
// master = cache side, slave = memory side.
interface dram_line_if #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned LINE_W = 128
);
  logic              req_en;
  logic              req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_data;
  logic              req_rdy;
  logic              rsp_en;
  logic [LINE_W-1:0] rsp_data;
  logic              rsp_rdy;

  modport master (
    output req_en, req_cmd, req_addr, req_data, rsp_rdy,
    input  req_rdy, rsp_en, rsp_data
  );

  modport slave (
    input  req_en, req_cmd, req_addr, req_data, rsp_rdy,
    output req_rdy, rsp_en, rsp_data
  );
endinterface

// File: rtl/dram_line_responder.sv
// In-order cache-line memory responder: queued line requests, fixed extra latency,
// block-RAM backing store, one request in service at a time.
module dram_line_responder #(
  parameter int unsigned ADDR_W      = 27,
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned ADDR_LSB    = 3,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic           sys_clk,
  input  logic           rst,
  dram_line_if.slave     bus,
  output logic           busy,
  output logic           overflow
);

  localparam int unsigned NumLines = 1 << DEPTH_LOG2;
  localparam int unsigned PtrW     = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned LatW     = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CntW-1:0] QFull = CntW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e state_q, state_d;

  // Request queue; only the line index of the address is kept.
  logic                  q_cmd  [QUEUE_DEPTH];
  logic [DEPTH_LOG2-1:0] q_idx  [QUEUE_DEPTH];
  logic [LINE_W-1:0]     q_data [QUEUE_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  req_rdy_q;
  logic                  overflow_q;
  logic                  push, pop;

  logic                  cur_cmd_q;
  logic [DEPTH_LOG2-1:0] cur_idx_q;
  logic [LINE_W-1:0]     cur_data_q;
  logic [LatW-1:0]       lat_q, lat_d;

  logic [LINE_W-1:0]     mem [NumLines];
  logic [LINE_W-1:0]     rd_q;
  logic                  ram_we, ram_re;

  logic unused_addr;
  assign unused_addr = ^bus.req_addr;

  assign push = bus.req_en & req_rdy_q;
  assign pop  = (state_q == StIdle) && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      req_rdy_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      req_rdy_q <= (cnt_d < QFull);
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (bus.req_en && !req_rdy_q) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      q_cmd[wr_ptr_q]  <= bus.req_cmd;
      q_idx[wr_ptr_q]  <= bus.req_addr[ADDR_LSB +: DEPTH_LOG2];
      q_data[wr_ptr_q] <= bus.req_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lat_q     <= '0;
      cur_cmd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (pop) cur_cmd_q <= q_cmd[rd_ptr_q];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (pop) begin
      cur_idx_q  <= q_idx[rd_ptr_q];
      cur_data_q <= q_data[rd_ptr_q];
    end
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          lat_d   = LatW'(LATENCY);
          state_d = (LATENCY == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (lat_q <= LatW'(1)) state_d = StAccess;
        else                   lat_d   = lat_q - LatW'(1);
      end
      StAccess: begin
        if (cur_cmd_q) begin
          ram_re  = 1'b1;
          state_d = StResp;
        end else begin
          ram_we  = 1'b1;
          state_d = StIdle;
        end
      end
      StResp: begin
        if (bus.rsp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write port is gated by rst so an access coinciding with reset is abandoned.
  always_ff @(posedge sys_clk) begin
    if (ram_we && !rst) mem[cur_idx_q] <= cur_data_q;
  end

  always_ff @(posedge sys_clk) begin
    if (rst)         rd_q <= '0;
    else if (ram_re) rd_q <= mem[cur_idx_q];
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.rsp_en   = (state_q == StResp);
  assign bus.rsp_data = rd_q;
  assign busy         = (cnt_q != '0) || (state_q != StIdle);
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_dram_line_responder.sv
// Directed bench for dram_line_responder: default build plus a LATENCY=0 build.
module tb_dram_line_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, overflow, busy0, overflow0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  dram_line_if #(.ADDR_W(27), .LINE_W(128)) bus ();
  dram_line_if #(.ADDR_W(27), .LINE_W(128)) bus0 ();

  dram_line_responder #(.LATENCY(4)) dut (
    .sys_clk  (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  dram_line_responder #(.LATENCY(0)) dut0 (
    .sys_clk  (clk),
    .rst      (rst),
    .bus      (bus0),
    .busy     (busy0),
    .overflow (overflow0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] line_mem [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic cmd, input logic [26:0] addr, input logic [127:0] data,
                      output int t);
    bus.req_en   = 1'b1;
    bus.req_cmd  = cmd;
    bus.req_addr = addr;
    bus.req_data = data;
    t = cyc;
    tick();
    bus.req_en = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int at, output logic [127:0] d,
                          output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.rsp_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    at = cyc;
    d  = bus.rsp_data;
  endtask

  task automatic wait_idle(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.req_rdy, bus.rsp_en, busy, overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.req_rdy, bus.rsp_en, busy, overflow});
    end
    checks++;
    if (bus.rsp_data !== 128'h0) begin
      failures++;
      $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data);
    end
    rst = 1'b0;
    checks++;
    if (bus.req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_first_cycle: got %b expected 0", bus.req_rdy);
    end
    tick();
    checks++;
    if (bus.req_rdy !== 1'b1 || bus0.req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy_rise: got %b%b expected 11", bus.req_rdy, bus0.req_rdy);
    end
  endtask

  task automatic test_write_read();
    int t, at;
    logic [127:0] d;
    logic ok;
    push(1'b0, 27'h0000010, 128'h0123456789ABCDEF_FEDCBA9876543210, t);
    wait_idle(30, ok);
    checks++;
    if (!ok || cyc !== t + 7) begin
      failures++;
      $display("FAIL write_busy_fall: got cycle %0d expected %0d", cyc - t, 7);
    end
    push(1'b1, 27'h0000010, 128'h0, t);
    wait_rsp(30, at, d, ok);
    checks++;
    if (!ok || at !== t + 7) begin
      failures++;
      $display("FAIL read_latency: got %0d expected 7", at - t);
    end
    checks++;
    if (d !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin
      failures++;
      $display("FAIL read_after_write: got %h expected %h", d,
               128'h0123456789ABCDEF_FEDCBA9876543210);
    end
    tick();
    checks++;
    if (bus.rsp_en !== 1'b0) begin
      failures++;
      $display("FAIL rsp_single_pulse: got %b expected 0", bus.rsp_en);
    end
    wait_idle(30, ok);
  endtask

  task automatic test_unwritten_alias();
    int t, at;
    logic [127:0] d;
    logic ok;
    push(1'b1, 27'h0000400, 128'h0, t);
    wait_rsp(30, at, d, ok);
    checks++;
    if (!ok || d !== 128'h0) begin
      failures++;
      $display("FAIL unwritten_zero: got %h expected 0 (ok=%b)", d, ok);
    end
    tick();
    push(1'b0, 27'h0002008, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, t);
    wait_idle(30, ok);
    push(1'b1, 27'h0000008, 128'h0, t);
    wait_rsp(30, at, d, ok);
    checks++;
    if (!ok || d !== 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0) begin
      failures++;
      $display("FAIL alias_line: got %h expected %h", d,
               128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
    end
    tick();
    wait_idle(30, ok);
  endtask

  task automatic test_back_to_back();
    int t, t0, at;
    logic [127:0] d;
    logic ok;
    logic [5:0] rdy_seen;
    int extra;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 27'h20 + 27'(8 * i), line_mem[i], t);
      wait_idle(30, ok);
    end
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      bus.req_en   = 1'b1;
      bus.req_cmd  = 1'b1;
      bus.req_addr = 27'h20 + 27'(8 * i);
      rdy_seen[i]  = bus.req_rdy;
      tick();
    end
    bus.req_en = 1'b0;
    // Pop of the first read frees a slot, so five of the six pushes land.
    checks++;
    if (rdy_seen !== 6'b011111) begin
      failures++;
      $display("FAIL b2b_rdy_pattern: got %b expected 011111", rdy_seen);
    end
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL b2b_overflow: got %b expected 1", overflow);
    end
    for (int k = 0; k < 5; k++) begin
      wait_rsp(30, at, d, ok);
      checks++;
      if (!ok || at !== t0 + 7 + 7 * k) begin
        failures++;
        $display("FAIL b2b_rsp_time%0d: got %0d expected %0d", k, at - t0, 7 + 7 * k);
      end
      checks++;
      if (d !== line_mem[k]) begin
        failures++;
        $display("FAIL b2b_rsp_data%0d: got %h expected %h", k, d, line_mem[k]);
      end
      tick();
    end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.rsp_en) extra++;
      tick();
    end
    checks++;
    if (extra !== 0 || busy !== 1'b0 || bus.req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drained: got extra=%0d busy=%b rdy=%b expected 0 0 1",
               extra, busy, bus.req_rdy);
    end
  endtask

  task automatic test_rsp_stall();
    int t, r, at;
    logic [127:0] d;
    logic ok;
    bus.rsp_rdy = 1'b0;
    push(1'b1, 27'h20, 128'h0, t);
    checks++;
    if (bus.req_rdy !== 1'b1) begin
      failures++;
      $display("FAIL stall_rdy: got %b expected 1", bus.req_rdy);
    end
    push(1'b1, 27'h28, 128'h0, r);
    wait_rsp(30, at, d, ok);
    checks++;
    if (!ok || at !== t + 7 || d !== line_mem[0]) begin
      failures++;
      $display("FAIL stall_first_rsp: got t=%0d d=%h expected t=7 d=%h", at - t, d,
               line_mem[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rsp_en !== 1'b1 || bus.rsp_data !== line_mem[0]) begin
        failures++;
        $display("FAIL stall_hold%0d: got en=%b d=%h expected en=1 d=%h", i, bus.rsp_en,
                 bus.rsp_data, line_mem[0]);
      end
    end
    bus.rsp_rdy = 1'b1;
    r = cyc;
    tick();
    checks++;
    if (bus.rsp_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: got %b expected 0", bus.rsp_en);
    end
    wait_rsp(30, at, d, ok);
    checks++;
    if (!ok || at !== r + 7 || d !== line_mem[1]) begin
      failures++;
      $display("FAIL stall_next_rsp: got t=%0d d=%h expected t=7 d=%h", at - r, d,
               line_mem[1]);
    end
    tick();
    wait_idle(30, ok);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_reset_mid_write();
    int t, at;
    logic [127:0] d;
    logic ok;
    push(1'b0, 27'h30, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, t);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, bus.req_rdy, bus.rsp_en, overflow} !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_flags: got %b expected 0000",
               {busy, bus.req_rdy, bus.rsp_en, overflow});
    end
    rst = 1'b0;
    tick();
    tick();
    push(1'b1, 27'h30, 128'h0, t);
    wait_rsp(30, at, d, ok);
    checks++;
    if (!ok || d !== line_mem[2]) begin
      failures++;
      $display("FAIL midrst_old_data: got %h expected %h", d, line_mem[2]);
    end
    tick();
    wait_idle(30, ok);
  endtask

  task automatic test_latency0();
    int t;
    logic ok;
    bus0.req_en   = 1'b1;
    bus0.req_cmd  = 1'b1;
    bus0.req_addr = 27'h0;
    t = cyc;
    tick();
    bus0.req_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.rsp_en) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok || cyc !== t + 3 || bus0.rsp_data !== 128'h0) begin
      failures++;
      $display("FAIL lat0_read: got t=%0d d=%h expected t=3 d=0", cyc - t, bus0.rsp_data);
    end
    tick();
  endtask

  initial begin
    bus.req_en   = 1'b0;
    bus.req_cmd  = 1'b0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.rsp_rdy  = 1'b1;
    bus0.req_en   = 1'b0;
    bus0.req_cmd  = 1'b0;
    bus0.req_addr = '0;
    bus0.req_data = '0;
    bus0.rsp_rdy  = 1'b1;
    line_mem[0] = 128'h11111111_00000000_AAAAAAAA_00000020;
    line_mem[1] = 128'h22222222_11111111_BBBBBBBB_00000028;
    line_mem[2] = 128'h33333333_22222222_CCCCCCCC_00000030;
    line_mem[3] = 128'h44444444_33333333_DDDDDDDD_00000038;
    line_mem[4] = 128'h55555555_44444444_EEEEEEEE_00000040;
    test_reset();
    test_write_read();
    test_unwritten_alias();
    test_back_to_back();
    test_rsp_stall();
    test_reset_mid_write();
    test_latency0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_line_responder.md
# dram_line_responder

Cache-line memory responder that terminates the cache-to-DRAM request channel: it accepts line requests (command, address, line data) from the L1 cache's master FIFO side and answers reads with full cache lines after a programmable latency. It stands in for the DRAM controller in simulation and on-board self-test builds. It sits where the FIFO request/response pair meets DRAM and uses the same encoding: cmd=1 read, cmd=0 write, and a response strobe with line data. Backing store is an inferred block RAM, in-order, one request in service at a time.

## Interface

- ADDR_W, 27, request address width (DRAM address, 16-bit word units)
- LINE_W, 128, cache line width in bits
- ADDR_LSB, 3, address bits below line granularity (LINE_W/16 = 8 words)
- DEPTH_LOG2, 10, log2 of number of stored lines
- LATENCY, 4, extra wait cycles inserted before each access (0 allowed)
- QUEUE_DEPTH, 4, request queue entries (power of two, >= 2)

- sys_clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_en  in  1  request strobe, one request per cycle with req_rdy
- req_cmd  in  1  1 = read line, 0 = write line
- req_addr  in  ADDR_W  line address
- req_data  in  LINE_W  write data (ignored for reads)
- req_rdy  out  1  queue can accept a request this cycle
- rsp_en  out  1  read response valid
- rsp_data  out  LINE_W  read line data
- rsp_rdy  in  1  consumer accepts response (codebase ties to 1)
- busy  out  1  queue non-empty or FSM not IDLE
- overflow  out  1  sticky: req_en seen while req_rdy low

## Operation

- Push: req_en & req_rdy stores {cmd, addr, data} in the queue. req_en with req_rdy low drops the request and sets overflow.
- Line index = req_addr[ADDR_LSB+DEPTH_LOG2-1 : ADDR_LSB]; higher bits ignored (aliasing is intentional), lower bits ignored.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: queue non-empty -> pop head into current-request registers, load wait counter with LATENCY; go WAIT (LATENCY>0) or ACCESS (LATENCY=0).
  - WAIT: decrement counter; at 1 -> ACCESS.
  - ACCESS: write -> store req_data at index, return to IDLE; read -> issue RAM read, go RESP.
  - RESP: rsp_en=1, rsp_data = RAM output, both held stable until rsp_rdy; on rsp_rdy -> IDLE.
- Writes produce no response. Requests complete strictly in arrival order, so read-after-write to the same index returns the written line.
- RAM contents initialise to all-zero at configuration; rst does not clear RAM.
- req_rdy is registered: next value = (next queue count < QUEUE_DEPTH), accounting for same-cycle push and pop.
- overflow clears only on rst.

## Timing

- Reset values: req_rdy=0, rsp_en=0, rsp_data=0, busy=0, overflow=0; queue empty, FSM IDLE. req_rdy rises the first cycle after rst deasserts.
- rst mid-operation: queue flushed, in-flight request abandoned (a write in WAIT is not committed), outputs take reset values the following cycle.
- Read pushed at cycle T into an empty queue with FSM in IDLE: pop at T+1, WAIT T+2..T+1+LATENCY, ACCESS T+2+LATENCY, rsp_en high at T+3+LATENCY (T+7 with default LATENCY=4).
- Write pushed at T: RAM updated at the end of cycle T+2+LATENCY; busy falls at T+3+LATENCY if nothing else is queued.
- Service interval: read LATENCY+3 cycles with rsp_rdy=1, write LATENCY+2 cycles; the next pop occurs on the cycle FSM returns to IDLE.
- Queue full with a simultaneous pop: req_rdy for the next cycle is computed from the post-pop count (stays 1 if a slot frees).
- rsp_rdy low in RESP: stall; the queue keeps accepting until full.

## Test plan

- Write 0x0123456789ABCDEF_FEDCBA9876543210 to addr 0x0000010, then read 0x0000010 -> single rsp_en pulse, 7 cycles after the read push, data equal to written line.
- Read never-written addr 0x0000400 -> rsp_data = 0; aliasing: write addr 0x0002008, read 0x0000008 (DEPTH_LOG2=10) -> same line returned.
- Push 6 back-to-back reads with QUEUE_DEPTH=4 -> req_rdy drops after the queue fills, dropped pushes set overflow=1, accepted reads answered in order.
- Hold rsp_rdy=0 for 5 cycles during RESP -> rsp_en and rsp_data stable throughout; one response on release, next request served afterwards.
- Assert rst while a write is in WAIT -> next cycle busy=0, req_rdy=0, rsp_en=0; a later read of that address returns the old contents.
- LATENCY=0 build: read pushed at T -> rsp_en at T+3.
